// File: rtl/prl_hr_pkg.sv
// Shared definitions for the USB-PD protocol-layer Hard/Cable Reset transmitter.
// The retry feature of prl_hard_reset_ctrl is enabled by defining PRL_HR_RETRY_EN.
package prl_hr_pkg;

  // Bit positions of the one-hot state encoding
  localparam int S_IDLE_B      = 0;
  localparam int S_WAIT_REQ_B  = 1;
  localparam int S_CONSTRUCT_B = 2;
  localparam int S_WAIT_ACK_B  = 3;
  localparam int S_SUCCESS_B   = 4;
  localparam int S_FAILURE_B   = 5;
  localparam int S_REPORT_B    = 6;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'(1) << S_IDLE_B,
    ST_WAIT_REQ  = 7'(1) << S_WAIT_REQ_B,
    ST_CONSTRUCT = 7'(1) << S_CONSTRUCT_B,
    ST_WAIT_ACK  = 7'(1) << S_WAIT_ACK_B,
    ST_SUCCESS   = 7'(1) << S_SUCCESS_B,
    ST_FAILURE   = 7'(1) << S_FAILURE_B,
    ST_REPORT    = 7'(1) << S_REPORT_B
  } prl_hr_state_t;

  // TRANSMIT[2:0] type codes that request reset signalling
  localparam logic [2:0] TX_HARD_RESET  = 3'b101;
  localparam logic [2:0] TX_CABLE_RESET = 3'b110;

  // ALERT register bit indices
  localparam int ALRT_HR_RX   = 3;
  localparam int ALRT_TX_FAIL = 4;
  localparam int ALRT_TX_OK   = 6;

  // True for the two type codes this block transmits; everything else is ignored
  function automatic logic is_reset_type(input logic [2:0] tx_type);
    return (tx_type == TX_HARD_RESET) || (tx_type == TX_CABLE_RESET);
  endfunction

endpackage

// File: rtl/prl_hr_timer.sv
// Cycle counter timing tHardResetComplete: clear/enable controlled,
// saturates at all-ones, flags the cycle in which the count equals TIMEOUT_CYC-1.
module prl_hr_timer
  import prl_hr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Count enabled cycles; clear has priority, and the count never wraps
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign term = (cnt_reg == CNT_TERM);

endmodule

// File: rtl/prl_hard_reset_ctrl.sv
// USB-PD protocol-layer Hard/Cable Reset transmitter (PRL_HR state machine).
// Holds a request to the PHY until ACK, timeout or a received Hard Reset, and
// reports the outcome through the ALERT register.
// Define PRL_HR_RETRY_EN to retry up to MAX_RETRY times after a timeout.
module prl_hard_reset_ctrl
  import prl_hr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        hr_req,
  input  logic [7:0]  ioTRANSMIT,
  input  logic [15:0] iAlert,
  input  logic        PHY_ACK,
  input  logic [15:0] alert_clr,
  output logic        phy_tx_req,
  output logic [2:0]  phy_tx_type,
  output logic [7:0]  oTRANSMIT,
  output logic [15:0] ALERT,
  output logic [7:0]  oRECEIVE_DETECT,
  output logic [7:0]  oRECEIVE_BYTE_COUNT,
  output logic        PHY_Stop_Attempting_Reset,
  output logic        busy
);

  // Elaboration-time marker for out-of-range parameter sets; carries no logic.
  if ((TIMEOUT_CYC < 2) || (MAX_RETRY > 7) || (CNT_W < 2)) begin : g_param_out_of_range
  end

  prl_hr_state_t state_reg, state_next;
  logic [2:0]    type_reg;
  logic          result_ok_reg;
  logic [7:0]    otransmit_reg;
  logic [7:0]    rx_detect_reg;
  logic [7:0]    rx_byte_cnt_reg;
  logic          stop_reg;
  logic [15:0]   alert_reg;
  logic [15:0]   alert_set;

  logic start;
  logic hr_rx_abort;
  logic timer_term;
  logic retry_ok;

  // Inputs bits this block has no use for
  logic unused_inputs;
  assign unused_inputs = ^{ioTRANSMIT[7:3], iAlert[15:ALRT_HR_RX+1], iAlert[ALRT_HR_RX-1:0]};

  assign start       = state_reg[S_WAIT_REQ_B] && hr_req && is_reset_type(ioTRANSMIT[2:0]);
  // A Hard Reset from the port partner pre-empts our own attempt
  assign hr_rx_abort = (state_reg[S_CONSTRUCT_B] || state_reg[S_WAIT_ACK_B]) && iAlert[ALRT_HR_RX];

  prl_hr_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timer (
    .CLK   (CLK),
    .reset (reset),
    .clr   (state_reg[S_CONSTRUCT_B]),
    .en    (state_reg[S_WAIT_ACK_B]),
    .term  (timer_term)
  );

`ifdef PRL_HR_RETRY_EN
  logic [2:0] retry_cnt_reg;

  assign retry_ok = (retry_cnt_reg < 3'(MAX_RETRY));

  // Count timed-out attempts of the current request
  always_ff @(posedge CLK) begin
    if (reset) begin
      retry_cnt_reg <= '0;
    end else if (start) begin
      retry_cnt_reg <= '0;
    end else if (state_reg[S_WAIT_ACK_B] && !hr_rx_abort && !PHY_ACK && timer_term && retry_ok) begin
      retry_cnt_reg <= retry_cnt_reg + 3'd1;
    end
  end
`else
  // A single timed-out attempt is final
  assign retry_ok = 1'b0;
`endif

  // Next-state decode; abort beats ACK, ACK beats timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      state_next = ST_WAIT_REQ;
      ST_WAIT_REQ:  if (start) state_next = ST_CONSTRUCT;
      ST_CONSTRUCT: state_next = hr_rx_abort ? ST_WAIT_REQ : ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (hr_rx_abort)     state_next = ST_WAIT_REQ;
        else if (PHY_ACK)    state_next = ST_SUCCESS;
        else if (timer_term) state_next = retry_ok ? ST_CONSTRUCT : ST_FAILURE;
      end
      ST_SUCCESS:   state_next = ST_REPORT;
      ST_FAILURE:   state_next = ST_REPORT;
      ST_REPORT:    state_next = ST_WAIT_REQ;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State register and register-file write-backs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      type_reg        <= 3'b000;
      result_ok_reg   <= 1'b0;
      otransmit_reg   <= 8'h00;
      rx_detect_reg   <= 8'h00;
      rx_byte_cnt_reg <= 8'h00;
      stop_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        type_reg        <= ioTRANSMIT[2:0];
        rx_detect_reg   <= 8'h00;
        rx_byte_cnt_reg <= (ioTRANSMIT[2:0] == TX_CABLE_RESET) ? 8'd1 : 8'd0;
        stop_reg        <= 1'b0;
      end
      if (state_reg[S_CONSTRUCT_B]) begin
        otransmit_reg <= {otransmit_reg[7:3], type_reg};
      end
      if (state_reg[S_SUCCESS_B]) begin
        result_ok_reg <= 1'b1;
      end
      if (state_reg[S_FAILURE_B]) begin
        result_ok_reg <= 1'b0;
        stop_reg      <= 1'b1;
      end
    end
  end

  // Alert events raised this cycle
  always_comb begin
    alert_set               = '0;
    alert_set[ALRT_HR_RX]   = hr_rx_abort;
    alert_set[ALRT_TX_OK]   = state_reg[S_REPORT_B] && result_ok_reg;
    alert_set[ALRT_TX_FAIL] = state_reg[S_REPORT_B] && !result_ok_reg;
  end

  // Sticky ALERT bits, write-1-to-clear; a new event in the same cycle wins
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_alert
    always_ff @(posedge CLK) begin
      if (reset) begin
        alert_reg[gi] <= 1'b0;
      end else begin
        alert_reg[gi] <= alert_set[gi] | (alert_reg[gi] & ~alert_clr[gi]);
      end
    end
  end

  assign phy_tx_req                = state_reg[S_WAIT_ACK_B];
  assign phy_tx_type               = state_reg[S_WAIT_ACK_B] ? type_reg : 3'b000;
  assign busy                      = !(state_reg[S_IDLE_B] || state_reg[S_WAIT_REQ_B]);
  assign oTRANSMIT                 = otransmit_reg;
  assign ALERT                     = alert_reg;
  assign oRECEIVE_DETECT           = rx_detect_reg;
  assign oRECEIVE_BYTE_COUNT       = rx_byte_cnt_reg;
  assign PHY_Stop_Attempting_Reset = stop_reg;

endmodule

// File: tb/tb_prl_hard_reset_ctrl.sv
// Directed bench for prl_hard_reset_ctrl (TIMEOUT_CYC=8, MAX_RETRY=2).
// Expectations follow PRL_HR_RETRY_EN when that macro is defined.
module tb_prl_hard_reset_ctrl;
  import prl_hr_pkg::*;

  logic        CLK;
  logic        reset;
  logic        hr_req;
  logic [7:0]  ioTRANSMIT;
  logic [15:0] iAlert;
  logic        PHY_ACK;
  logic [15:0] alert_clr;
  logic        phy_tx_req;
  logic [2:0]  phy_tx_type;
  logic [7:0]  oTRANSMIT;
  logic [15:0] ALERT;
  logic [7:0]  oRECEIVE_DETECT;
  logic [7:0]  oRECEIVE_BYTE_COUNT;
  logic        PHY_Stop_Attempting_Reset;
  logic        busy;

  int n_pass;
  int n_total;

`ifdef PRL_HR_RETRY_EN
  localparam int TO_HI = 24, TO_PULSES = 3, TO_GAPS = 2, TO_DONE = 30;
`else
  localparam int TO_HI = 8, TO_PULSES = 1, TO_GAPS = 0, TO_DONE = 12;
`endif

  prl_hard_reset_ctrl #(
    .TIMEOUT_CYC (8),
    .CNT_W       (16),
    .MAX_RETRY   (2)
  ) dut (
    .CLK                       (CLK),
    .reset                     (reset),
    .hr_req                    (hr_req),
    .ioTRANSMIT                (ioTRANSMIT),
    .iAlert                    (iAlert),
    .PHY_ACK                   (PHY_ACK),
    .alert_clr                 (alert_clr),
    .phy_tx_req                (phy_tx_req),
    .phy_tx_type               (phy_tx_type),
    .oTRANSMIT                 (oTRANSMIT),
    .ALERT                     (ALERT),
    .oRECEIVE_DETECT           (oRECEIVE_DETECT),
    .oRECEIVE_BYTE_COUNT       (oRECEIVE_BYTE_COUNT),
    .PHY_Stop_Attempting_Reset (PHY_Stop_Attempting_Reset),
    .busy                      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  tx;
    int          ack_at;   // WAIT_ACK cycle index that gets PHY_ACK, -1 = never
    logic [2:0]  typ;
    int          first;    // cycle phy_tx_req first high (hr_req cycle = 0)
    int          hi;
    int          pulses;
    int          gaps;
    int          done;     // cycle busy returns to 0
    logic [15:0] alert;
    logic        stop;
    logic        rbc;
    logic [2:0]  otx;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic clear_alerts();
    alert_clr = 16'hFFFF;
    step();
    alert_clr = 16'h0000;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " phy_tx_req"}, 32'(phy_tx_req), 32'd0);
    chk({tag, " phy_tx_type"}, 32'(phy_tx_type), 32'd0);
    chk({tag, " oTRANSMIT"}, 32'(oTRANSMIT), 32'd0);
    chk({tag, " ALERT"}, 32'(ALERT), 32'd0);
    chk({tag, " oRECEIVE_DETECT"}, 32'(oRECEIVE_DETECT), 32'd0);
    chk({tag, " oRECEIVE_BYTE_COUNT"}, 32'(oRECEIVE_BYTE_COUNT), 32'd0);
    chk({tag, " stop"}, 32'(PHY_Stop_Attempting_Reset), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int first_req, hi, pulses, last_hi, done, alert_c, type_bad, gaps;
    logic prev_req, seen_busy;

    n_pass = 0;
    n_total = 0;
    reset = 1'b1; hr_req = 1'b0; ioTRANSMIT = 8'h00; iAlert = 16'h0000;
    PHY_ACK = 1'b0; alert_clr = 16'h0000;

    vecs[0] = '{8'h05,  3, 3'd5,  2, 4,     1,         0,       8,       16'h0040, 1'b0, 1'b0, 3'd5};
    vecs[1] = '{8'h06,  0, 3'd6,  2, 1,     1,         0,       5,       16'h0040, 1'b0, 1'b1, 3'd6};
    vecs[2] = '{8'h05, -1, 3'd5,  2, TO_HI, TO_PULSES, TO_GAPS, TO_DONE, 16'h0010, 1'b1, 1'b0, 3'd5};
    vecs[3] = '{8'h06,  7, 3'd6,  2, 8,     1,         0,       12,      16'h0040, 1'b0, 1'b1, 3'd6};
    vecs[4] = '{8'h03, -1, 3'd0, -1, 0,     0,         0,       -1,      16'h0000, 1'b0, 1'b1, 3'd6};
    vecs[5] = '{8'hF5,  1, 3'd5,  2, 2,     1,         0,       6,       16'h0040, 1'b0, 1'b0, 3'd5};

    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();   // IDLE -> WAIT_REQ

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      clear_alerts();
      ioTRANSMIT = vecs[i].tx;
      hr_req = 1'b1;
      first_req = -1; hi = 0; pulses = 0; last_hi = -1; done = -1; alert_c = -1;
      type_bad = 0; prev_req = 1'b0; seen_busy = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        step();
        hr_req = 1'b0;
        if (phy_tx_req) begin
          if (first_req < 0) first_req = c;
          if (!prev_req) pulses++;
          if (phy_tx_type != vecs[i].typ) type_bad++;
          PHY_ACK = (hi == vecs[i].ack_at);
          hi++;
          last_hi = c;
        end else begin
          PHY_ACK = 1'b0;
        end
        if (busy) seen_busy = 1'b1;
        else if (seen_busy && done < 0) done = c;
        if (ALERT != 16'h0000 && alert_c < 0) alert_c = c;
        prev_req = phy_tx_req;
      end
      PHY_ACK = 1'b0;
      gaps = (hi == 0) ? 0 : (last_hi - first_req + 1) - hi;
      $display("vec %0d: tx=%02h req@%0d hi=%0d pulses=%0d done@%0d ALERT=%04h", i, vecs[i].tx,
               first_req, hi, pulses, done, ALERT);
      chk($sformatf("v%0d first_req", i), 32'(first_req), 32'(vecs[i].first));
      chk($sformatf("v%0d req_cycles", i), 32'(hi), 32'(vecs[i].hi));
      chk($sformatf("v%0d pulses", i), 32'(pulses), 32'(vecs[i].pulses));
      chk($sformatf("v%0d gaps", i), 32'(gaps), 32'(vecs[i].gaps));
      chk($sformatf("v%0d type_errs", i), 32'(type_bad), 32'd0);
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("v%0d alert_cycle", i), 32'(alert_c), 32'(vecs[i].done));
      chk($sformatf("v%0d ALERT", i), 32'(ALERT), 32'(vecs[i].alert));
      chk($sformatf("v%0d stop", i), 32'(PHY_Stop_Attempting_Reset), 32'(vecs[i].stop));
      chk($sformatf("v%0d rbc", i), 32'(oRECEIVE_BYTE_COUNT), 32'(vecs[i].rbc));
      chk($sformatf("v%0d rdet", i), 32'(oRECEIVE_DETECT), 32'd0);
      chk($sformatf("v%0d otx", i), 32'(oTRANSMIT[2:0]), 32'(vecs[i].otx));
    end

    // Abort: partner Hard Reset in the 4th WAIT_ACK cycle
    clear_alerts();
    ioTRANSMIT = 8'h05;
    hr_req = 1'b1;
    step(); hr_req = 1'b0;           // c1 CONSTRUCT
    repeat (4) step();               // c5 = 4th WAIT_ACK cycle
    chk("abort pre req", 32'(phy_tx_req), 32'd1);
    iAlert = 16'h0008;
    step();                          // c6
    iAlert = 16'h0000;
    $display("abort: req=%0b ALERT=%04h busy=%0b", phy_tx_req, ALERT, busy);
    chk("abort req", 32'(phy_tx_req), 32'd0);
    chk("abort ALERT", 32'(ALERT), 32'h0008);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort state", 32'(dut.state_reg), 32'(ST_WAIT_REQ));
    repeat (12) step();
    chk("abort ALERT later", 32'(ALERT), 32'h0008);

    // Reset in the middle of WAIT_ACK
    ioTRANSMIT = 8'h06;
    hr_req = 1'b1;
    step(); hr_req = 1'b0;
    step(); step();                  // c3, WAIT_ACK
    chk("midrst pre req", 32'(phy_tx_req), 32'd1);
    reset = 1'b1;
    step();
    $display("mid-reset: req=%0b otx=%02h ALERT=%04h", phy_tx_req, oTRANSMIT, ALERT);
    check_all_zero("midrst");
    reset = 1'b0;
    step();

    // Clear racing a set, and hr_req while busy
    clear_alerts();
    ioTRANSMIT = 8'h05;
    hr_req = 1'b1;
    step(); hr_req = 1'b0;           // c1
    step(); PHY_ACK = 1'b1;          // c2 WAIT_ACK idx0
    step(); PHY_ACK = 1'b0;          // c3 SUCCESS
    ioTRANSMIT = 8'h06; hr_req = 1'b1;
    step(); hr_req = 1'b0;           // c4 REPORT
    alert_clr = 16'h0040;
    step();                          // c5
    $display("clr race: ALERT=%04h busy=%0b", ALERT, busy);
    chk("race ALERT", 32'(ALERT), 32'h0040);
    chk("race busy", 32'(busy), 32'd0);
    step();                          // c6
    alert_clr = 16'h0000;
    chk("clr ALERT", 32'(ALERT), 32'h0000);
    step();
    chk("busy-req ignored", 32'(busy), 32'd0);
    chk("busy-req rbc", 32'(oRECEIVE_BYTE_COUNT), 32'd0);
    chk("busy-req otx", 32'(oTRANSMIT[2:0]), 32'd5);

`ifdef PRL_HR_RETRY_EN
    // ACK during the second attempt
    clear_alerts();
    ioTRANSMIT = 8'h05;
    hr_req = 1'b1;
    hi = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      hr_req = 1'b0;
      if (phy_tx_req) hi++;
      PHY_ACK = (c == 12);
    end
    PHY_ACK = 1'b0;
    $display("retry ack: hi=%0d ALERT=%04h busy=%0b", hi, ALERT, busy);
    chk("retry2 hi", 32'(hi), 32'd10);
    chk("retry2 ALERT", 32'(ALERT), 32'h0040);
    chk("retry2 stop", 32'(PHY_Stop_Attempting_Reset), 32'd0);
    chk("retry2 busy", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
